decay_tdc: RTL and testbench
============================

DECAY_TDC -- requirements
Module: decay_tdc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk clocks all state, and rst is sampled on the clk rising edge.
REQ-002 Port clk, input, 1 bit: 100 MHz system clock; every interval tick is one clk period (10 ns).
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start_in, input, 1 bit: level from the upper-paddle coincidence (muon stop); already synchronous to clk.
REQ-005 Port stop_in, input, 1 bit: level from the decay-electron coincidence; already synchronous to clk.
REQ-006 Port clear, input, 1 bit: synchronous soft clear from the debounced button.
REQ-007 Port digits, output, 16 bits: last interval as 4-digit packed BCD, [15:12] most significant; feeds the display mode D.
REQ-008 Port valid, output, 1 bit: one-cycle pulse when digits updates.
REQ-009 Port busy, output, 1 bit: high while state is RUN.
REQ-010 Port overflow, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-011 An event SHALL be a rising edge: x_in high and x_prev low, where x_prev is x_in registered one cycle earlier; the edge is used combinationally, with no added latency.
REQ-012 The FSM SHALL have two states: IDLE and RUN.
REQ-013 In IDLE, a start edge SHALL cause: state goes to RUN and cnt is loaded with BCD 0001 on the same edge.
REQ-014 In RUN with no stop edge and cnt not equal to 9999, cnt SHALL increment by 1 in BCD each cycle, with decimal carry per nibble.
REQ-015 In RUN with a stop edge, the block SHALL register digits equal to cnt, pulse valid, and return to IDLE on that edge. An interval of k cycles between start edge and stop edge SHALL yield digits = k.
REQ-016 In RUN with cnt equal to 9999 and no stop edge, the block SHALL pulse overflow, return to IDLE and leave digits unchanged.
REQ-017 A stop edge while cnt equals 9999 SHALL take priority over timeout: digits becomes 9999, valid pulses, and overflow stays low.
REQ-018 Start and stop edges in the same cycle while in IDLE: start SHALL be accepted and stop ignored. The minimum measurable interval is therefore 0001.
REQ-019 A start edge in RUN SHALL be ignored (no retrigger). If start and stop coincide in RUN, the stop SHALL complete the measurement and the start SHALL NOT re-arm.
REQ-020 A stop edge in IDLE SHALL be ignored.
REQ-021 clear SHALL, on the next edge, force IDLE, digits to 0000 and cnt to 0000, and suppress valid and overflow in that cycle. clear SHALL have priority over all events except rst.
REQ-022 digits, valid, busy and overflow SHALL all be registered outputs; valid and overflow SHALL never assert in the same cycle.

Reset
REQ-023 When rst is high, the block SHALL set: state IDLE, cnt 0000, digits 0000, valid 0, overflow 0, busy 0.
REQ-024 Reset SHALL set start_prev and stop_prev to 1, so an input already high at reset release generates no event.
REQ-025 rst asserted during RUN SHALL abandon the measurement with no valid or overflow pulse.

Structure
REQ-026 A shared package muon_pkg SHALL hold the state enumeration (IDLE, RUN) and the constant TDC_MAX_BCD = 16'h9999.
REQ-027 The 4-digit BCD increment SHALL be a combinational sub-module, bcd_incr4 (in 16, out 16, 9999 wraps to 0000), reusable by the event counters.
REQ-028 The block SHALL contain no binary-to-BCD conversion and no multi-cycle arithmetic.

Verification
REQ-029 The bench SHALL check: start edge at cycle 10, stop edge at cycle 230 -> digits = 16'h0220 and valid high for exactly one cycle at cycle 231.
REQ-030 The bench SHALL check: stop edge one cycle after the start edge -> digits = 0001. Simultaneous start and stop in IDLE -> busy = 1 and no valid pulse.
REQ-031 The bench SHALL check: start edge with no stop -> after 9999 RUN cycles overflow pulses once, busy drops, digits keeps its previous value (for example 0220).
REQ-032 The bench SHALL check: stop edge exactly when cnt = 9999 -> digits = 9999, valid = 1, overflow = 0.
REQ-033 The bench SHALL check: second start edge at cnt 0050, then stop edge 100 cycles after the first start -> digits = 0100, and the second start is ignored.
REQ-034 The bench SHALL check: start_in held high through rst release -> no RUN. clear at cnt 0400 -> IDLE, digits 0000, no valid pulse.

Source files
------------

// File: rtl/muon_pkg.sv
// Shared definitions for the muon-lifetime front end: BCD widths, the TDC
// state enumeration and the TDC full-scale count.
package muon_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  typedef logic [BCD_W-1:0] bcd4_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdc_state_e;

  localparam bcd4_t TDC_MAX_BCD = 16'h9999;
  localparam bcd4_t BCD_ZERO    = 16'h0000;
  localparam bcd4_t BCD_ONE     = 16'h0001;

endpackage

// File: rtl/decay_tdc_if.sv
// Event/result bundle of the decay TDC.
//   start_in, stop_in : coincidence levels, synchronous to clk
//   clear             : synchronous soft clear
//   digits            : last interval, 4-digit packed BCD
//   valid             : one-cycle pulse when digits updates
//   busy              : measurement in progress
//   overflow          : one-cycle pulse on timeout
// master drives the event inputs, slave is the TDC.
interface decay_tdc_if;

  logic            start_in;
  logic            stop_in;
  logic            clear;
  muon_pkg::bcd4_t digits;
  logic            valid;
  logic            busy;
  logic            overflow;

  modport master (
    output start_in, stop_in, clear,
    input  digits, valid, busy, overflow
  );

  modport slave (
    input  start_in, stop_in, clear,
    output digits, valid, busy, overflow
  );

endinterface

// File: rtl/bcd_incr4.sv
// Combinational 4-digit packed-BCD increment; 9999 wraps to 0000.
//   din  : BCD value
//   dout : din + 1 in BCD
module bcd_incr4
  import muon_pkg::*;
(
  input  bcd4_t din,
  output bcd4_t dout
);

  // Ripple the decimal carry from the least significant nibble upward.
  always_comb begin
    logic carry;
    carry = 1'b1;
    dout  = BCD_ZERO;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (carry) begin
        if (din[4*i +: 4] >= 4'd9) begin
          dout[4*i +: 4] = 4'd0;
        end else begin
          dout[4*i +: 4] = din[4*i +: 4] + 4'd1;
          carry          = 1'b0;
        end
      end else begin
        dout[4*i +: 4] = din[4*i +: 4];
      end
    end
  end

endmodule

// File: rtl/decay_tdc.sv
// Muon decay time-to-digital converter. Counts clk periods in BCD from a
// start edge to a stop edge and publishes the interval on digits.
//   clk  : 100 MHz system clock, one count per period
//   rst  : synchronous active-high reset
//   bus  : decay_tdc_if.slave (start_in, stop_in, clear in;
//          digits, valid, busy, overflow out, all registered)
module decay_tdc
  import muon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  decay_tdc_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0] state, state_nxt;
  bcd4_t      cnt, cnt_nxt, cnt_inc;
  bcd4_t      digits_q, digits_nxt;
  logic       valid_q, valid_nxt;
  logic       overflow_q, overflow_nxt;
  logic       busy_q;
  logic       start_prev, stop_prev;
  logic       start_edge_c, stop_edge_c;

  // Rising edges used in the same cycle they are seen.
  assign start_edge_c = bus.start_in & ~start_prev;
  assign stop_edge_c  = bus.stop_in  & ~stop_prev;

  bcd_incr4 u_incr (
    .din  (cnt),
    .dout (cnt_inc)
  );

  // Next-state and output decode; clear outranks every event.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    digits_nxt   = digits_q;
    valid_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    if (bus.clear) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = BCD_ZERO;
      digits_nxt = BCD_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          // A simultaneous stop edge is dropped: interval starts at 0001.
          if (start_edge_c) begin
            state_nxt = ST_RUN;
            cnt_nxt   = BCD_ONE;
          end
        end
        ST_RUN: begin
          // Stop wins over timeout; start edges are never retriggers.
          if (stop_edge_c) begin
            digits_nxt = cnt;
            valid_nxt  = 1'b1;
            state_nxt  = ST_IDLE;
          end else if (cnt == TDC_MAX_BCD) begin
            overflow_nxt = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counter and output registers. Edge history resets high so a
  // level already present at reset release is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= BCD_ZERO;
      digits_q   <= BCD_ZERO;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digits_q   <= digits_nxt;
      valid_q    <= valid_nxt;
      overflow_q <= overflow_nxt;
      busy_q     <= (state_nxt == ST_RUN);
      start_prev <= bus.start_in;
      stop_prev  <= bus.stop_in;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_decay_tdc.sv
// Directed bench for decay_tdc: a table of start/stop intervals plus
// hand-written sequences for timeout, clear, reset and edge corner cases.
module tb_decay_tdc;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  decay_tdc_if bus ();

  decay_tdc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: first edge with rst low is cycle 1.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int          gap;
    logic [15:0] exp_digits;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start edge, stop edge 'gap' cycles later; report outputs after the stop
  // edge and one cycle later, then return inputs low.
  task automatic measure(input int gap,
                         output logic [15:0] d, output logic v, output logic o,
                         output logic v_after, output logic b_after);
    bus.start_in = 1'b1;
    tick();
    repeat (gap - 1) tick();
    bus.stop_in = 1'b1;
    tick();
    d = bus.digits;
    v = bus.valid;
    o = bus.overflow;
    tick();
    v_after = bus.valid;
    b_after = bus.busy;
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic        v, o, va, ba;
    int          n;
    int          pre_valid;
    logic        got;

    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{1,    16'h0001};
    vecs[1]  = '{2,    16'h0002};
    vecs[2]  = '{9,    16'h0009};
    vecs[3]  = '{10,   16'h0010};
    vecs[4]  = '{19,   16'h0019};
    vecs[5]  = '{99,   16'h0099};
    vecs[6]  = '{100,  16'h0100};
    vecs[7]  = '{999,  16'h0999};
    vecs[8]  = '{1000, 16'h1000};
    vecs[9]  = '{1234, 16'h1234};
    vecs[10] = '{9999, 16'h9999};

    // Reset values.
    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    bus.clear    = 1'b0;
    tick();
    tick();
    check16("rst_digits", bus.digits, 16'h0000);
    check1("rst_valid", bus.valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_overflow", bus.overflow, 1'b0);
    rst = 1'b0;

    // Start edge at cycle 10, stop edge at cycle 230.
    pre_valid = 0;
    while (cyc < 9) begin
      tick();
      if (bus.valid) pre_valid++;
    end
    bus.start_in = 1'b1;
    tick();
    check_int("start_cycle", cyc, 10);
    while (cyc < 229) begin
      tick();
      if (bus.valid) pre_valid++;
    end
    bus.stop_in = 1'b1;
    tick();
    check_int("stop_cycle", cyc, 230);
    check16("c230_digits", bus.digits, 16'h0220);
    check1("c231_valid", bus.valid, 1'b1);
    check_int("c230_pre_valid", pre_valid, 0);
    tick();
    check1("c232_valid_low", bus.valid, 1'b0);
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    tick();

    // Timeout: no stop edge, digits keeps 0220.
    bus.start_in = 1'b1;
    tick();
    n = 0;
    got = 1'b0;
    pre_valid = 0;
    while (!got && n < 10005) begin
      tick();
      n++;
      if (bus.valid) pre_valid++;
      if (bus.overflow) got = 1'b1;
    end
    check1("ovf_seen", got, 1'b1);
    check_int("ovf_latency", n, 9999);
    check1("ovf_busy", bus.busy, 1'b0);
    check16("ovf_digits", bus.digits, 16'h0220);
    check_int("ovf_no_valid", pre_valid, 0);
    tick();
    check1("ovf_single", bus.overflow, 1'b0);
    bus.start_in = 1'b0;
    tick();

    // Interval table, including stop exactly at 9999.
    for (int i = 0; i < 11; i++) begin
      measure(vecs[i].gap, d, v, o, va, ba);
      check16($sformatf("vec%0d_digits", i), d, vecs[i].exp_digits);
      check1($sformatf("vec%0d_valid", i), v, 1'b1);
      check1($sformatf("vec%0d_overflow", i), o, 1'b0);
      check1($sformatf("vec%0d_valid_after", i), va, 1'b0);
      check1($sformatf("vec%0d_busy_after", i), ba, 1'b0);
    end

    // Simultaneous start and stop in IDLE: start wins, stop dropped.
    bus.start_in = 1'b1;
    bus.stop_in  = 1'b1;
    tick();
    check1("simul_busy", bus.busy, 1'b1);
    check1("simul_valid", bus.valid, 1'b0);
    pre_valid = 0;
    repeat (3) begin
      tick();
      if (bus.valid) pre_valid++;
    end
    check_int("simul_no_valid", pre_valid, 0);
    bus.stop_in = 1'b0;
    tick();
    bus.stop_in = 1'b1;
    tick();
    check16("simul_digits", bus.digits, 16'h0005);
    check1("simul_late_valid", bus.valid, 1'b1);
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    tick();

    // Retrigger at cnt 0050 ignored; start+stop coinciding at 0100.
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    repeat (49) tick();
    bus.start_in = 1'b1;
    tick();
    check1("retrig_busy", bus.busy, 1'b1);
    repeat (9) tick();
    bus.start_in = 1'b0;
    repeat (40) tick();
    bus.start_in = 1'b1;
    bus.stop_in  = 1'b1;
    tick();
    check16("retrig_digits", bus.digits, 16'h0100);
    check1("retrig_valid", bus.valid, 1'b1);
    tick();
    check1("retrig_no_rearm", bus.busy, 1'b0);
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    tick();

    // Clear at cnt 0400, together with a stop edge.
    bus.start_in = 1'b1;
    tick();
    repeat (399) tick();
    bus.clear   = 1'b1;
    bus.stop_in = 1'b1;
    tick();
    check1("clr_busy", bus.busy, 1'b0);
    check16("clr_digits", bus.digits, 16'h0000);
    check1("clr_valid", bus.valid, 1'b0);
    check1("clr_overflow", bus.overflow, 1'b0);
    bus.clear = 1'b0;
    tick();
    check1("clr_valid_after", bus.valid, 1'b0);
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    tick();

    // Reset during RUN abandons the measurement silently.
    bus.start_in = 1'b1;
    tick();
    repeat (20) tick();
    check1("rstrun_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    check1("rstrun_busy", bus.busy, 1'b0);
    check1("rstrun_valid", bus.valid, 1'b0);
    check1("rstrun_overflow", bus.overflow, 1'b0);

    // start_in held high through reset release: no event.
    tick();
    rst = 1'b0;
    got = 1'b0;
    repeat (5) begin
      tick();
      if (bus.busy) got = 1'b1;
    end
    check1("held_no_run", got, 1'b0);
    bus.start_in = 1'b0;
    tick();
    bus.start_in = 1'b1;
    tick();
    check1("held_fresh_edge", bus.busy, 1'b1);
    bus.start_in = 1'b0;
    bus.clear    = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
